// File: rtl/known_sinks_pkg.sv
// Shared constants and state encoding for the knownSinks table, used by
// both the writer that builds it and the reader that checks membership.
package known_sinks_pkg;

    localparam int WORD_WIDTH       = 16;
    localparam int MAX_SINKS        = 16;
    localparam int SINK_ENTRY_BYTES = 2;
    localparam logic [WORD_WIDTH-1:0] KNOWN_SINKS_BASE = 16'h0000;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        WRITE
    } state_e;

endpackage

// File: rtl/known_sinks_writer.sv
// Appends announced sink IDs to the knownSinks table in shared memory,
// skipping IDs already present and dropping new ones once the table is full.
module known_sinks_writer
    import known_sinks_pkg::*;
#(
    parameter int                             WORD_WIDTH = known_sinks_pkg::WORD_WIDTH,
    parameter int                             MAX_SINKS  = known_sinks_pkg::MAX_SINKS,
    parameter logic [known_sinks_pkg::WORD_WIDTH-1:0] BASE_ADDR = known_sinks_pkg::KNOWN_SINKS_BASE
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [WORD_WIDTH-1:0] sink_id,
    input  logic                  sink_valid,
    output logic                  sink_ready,
    output logic [WORD_WIDTH-1:0] mem_address,
    input  logic [WORD_WIDTH-1:0] mem_rd_data,
    output logic [WORD_WIDTH-1:0] mem_wr_data,
    output logic                  mem_wr_en,
    output logic [4:0]            sink_count,
    output logic                  full,
    output logic                  new_sink,
    output logic                  duplicate,
    output logic                  dropped
);

    state_e                state_q, state_d;
    logic [WORD_WIDTH-1:0] id_q, id_d;
    logic [4:0]            idx_q, idx_d;
    logic [4:0]            count_q, count_d;
    logic                  newSink_q, newSink_d;
    logic                  duplicate_q, duplicate_d;
    logic                  dropped_q, dropped_d;
    logic                  writeReq;

    // Entries are word-sized, so the byte offset is the index doubled.
    function automatic logic [WORD_WIDTH-1:0] entryAddr(input logic [4:0] index);
        return BASE_ADDR + (WORD_WIDTH'(index) << 1);
    endfunction

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            state_q     <= IDLE;
            id_q        <= '0;
            idx_q       <= '0;
            count_q     <= '0;
            newSink_q   <= 1'b0;
            duplicate_q <= 1'b0;
            dropped_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            idx_q       <= idx_d;
            count_q     <= count_d;
            newSink_q   <= newSink_d;
            duplicate_q <= duplicate_d;
            dropped_q   <= dropped_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        idx_d       = idx_q;
        count_d     = count_q;
        newSink_d   = 1'b0;
        duplicate_d = 1'b0;
        dropped_d   = 1'b0;
        sink_ready  = 1'b0;
        mem_address = BASE_ADDR;
        writeReq    = 1'b0;

        unique case (state_q)
            IDLE: begin
                sink_ready = 1'b1;
                if (sink_valid) begin
                    id_d    = sink_id;
                    idx_d   = '0;
                    state_d = (count_q != 5'd0) ? SCAN : WRITE;
                end
            end
            SCAN: begin
                mem_address = entryAddr(idx_q);
                // Only populated entries are visited, so stale words past count never match.
                if (mem_rd_data == id_q) begin
                    duplicate_d = 1'b1;
                    state_d     = IDLE;
                end else if (idx_q == count_q - 5'd1) begin
                    if (count_q < 5'(MAX_SINKS)) begin
                        state_d = WRITE;
                    end else begin
                        dropped_d = 1'b1;
                        state_d   = IDLE;
                    end
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            WRITE: begin
                mem_address = entryAddr(count_q);
                writeReq    = 1'b1;
                count_d     = count_q + 5'd1;
                newSink_d   = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Gating keeps memory untouched on an edge that resets or clears the table.
    assign mem_wr_en   = writeReq && !reset && !clear;
    assign mem_wr_data = id_q;
    assign sink_count  = count_q;
    assign full        = (count_q == 5'(MAX_SINKS));
    assign new_sink    = newSink_q;
    assign duplicate   = duplicate_q;
    assign dropped     = dropped_q;

endmodule

// File: tb/tb_known_sinks_writer.sv
// Directed bench for known_sinks_writer with a small word memory model
// behind the asynchronous-read port.
module tb_known_sinks_writer;

    logic        clock;
    logic        reset;
    logic        clear;
    logic [15:0] sink_id;
    logic        sink_valid;
    logic        sink_ready;
    logic [15:0] mem_address;
    logic [15:0] mem_rd_data;
    logic [15:0] mem_wr_data;
    logic        mem_wr_en;
    logic [4:0]  sink_count;
    logic        full;
    logic        new_sink;
    logic        duplicate;
    logic        dropped;

    logic [15:0] mem [0:255];

    int testCount = 0;
    int failCount = 0;

    known_sinks_writer dut (
        .clock       (clock),
        .reset       (reset),
        .clear       (clear),
        .sink_id     (sink_id),
        .sink_valid  (sink_valid),
        .sink_ready  (sink_ready),
        .mem_address (mem_address),
        .mem_rd_data (mem_rd_data),
        .mem_wr_data (mem_wr_data),
        .mem_wr_en   (mem_wr_en),
        .sink_count  (sink_count),
        .full        (full),
        .new_sink    (new_sink),
        .duplicate   (duplicate),
        .dropped     (dropped)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign mem_rd_data = mem[mem_address[8:1]];

    always @(posedge clock) begin
        if (mem_wr_en) mem[mem_address[8:1]] <= mem_wr_data;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Offers one ID from IDLE and follows it to its status pulse; kind 1=new, 2=duplicate, 3=dropped.
    task automatic applyStimulus(input logic [15:0] id, output int pulseCycle, output int pulseKind,
                                 output int writes, output logic [15:0] wrAddr);
        sink_id    = id;
        sink_valid = 1'b1;
        step();
        sink_valid = 1'b0;
        pulseCycle = -1;
        pulseKind  = 0;
        writes     = 0;
        wrAddr     = 16'hFFFF;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (mem_wr_en) begin
                writes++;
                wrAddr = mem_address;
            end
            if (new_sink || duplicate || dropped) begin
                pulseCycle = cyc;
                pulseKind  = new_sink ? 1 : (duplicate ? 2 : 3);
                break;
            end
            step();
        end
    endtask

    task automatic checkIdleResetValues(input string tag);
        checkOutput({tag, "_ready"}, 32'(sink_ready), 32'd1);
        checkOutput({tag, "_addr"}, 32'(mem_address), 32'h0000);
        checkOutput({tag, "_wrdata"}, 32'(mem_wr_data), 32'h0000);
        checkOutput({tag, "_wren"}, 32'(mem_wr_en), 32'd0);
        checkOutput({tag, "_count"}, 32'(sink_count), 32'd0);
        checkOutput({tag, "_full"}, 32'(full), 32'd0);
        checkOutput({tag, "_pulses"}, {29'd0, new_sink, duplicate, dropped}, 32'd0);
    endtask

    initial begin
        int          pc;
        int          pk;
        int          wr;
        logic [15:0] wa;

        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        reset      = 1'b1;
        clear      = 1'b0;
        sink_valid = 1'b0;
        sink_id    = 16'h0000;
        step();
        step();
        checkIdleResetValues("reset");
        reset = 1'b0;
        step();

        // Empty table: write in cycle 1, new_sink in cycle 2.
        sink_id    = 16'h0005;
        sink_valid = 1'b1;
        step();
        sink_valid = 1'b0;
        checkOutput("empty_c1_wren", 32'(mem_wr_en), 32'd1);
        checkOutput("empty_c1_addr", 32'(mem_address), 32'h0000);
        checkOutput("empty_c1_data", 32'(mem_wr_data), 32'h0005);
        checkOutput("empty_c1_ready", 32'(sink_ready), 32'd0);
        step();
        checkOutput("empty_c2_new", 32'(new_sink), 32'd1);
        checkOutput("empty_c2_count", 32'(sink_count), 32'd1);
        checkOutput("empty_c2_ready", 32'(sink_ready), 32'd1);
        checkOutput("empty_mem0", 32'(mem[0]), 32'h0005);

        applyStimulus(16'h0009, pc, pk, wr, wa);
        checkOutput("second_cycle", 32'(pc), 32'd3);
        checkOutput("second_addr", 32'(wa), 32'h0002);

        // Duplicate at entry 1: SCAN reads 0x0000 then 0x0002, pulse in cycle 3.
        sink_id    = 16'h0009;
        sink_valid = 1'b1;
        step();
        sink_valid = 1'b0;
        checkOutput("dup_c1_addr", 32'(mem_address), 32'h0000);
        checkOutput("dup_c1_wren", 32'(mem_wr_en), 32'd0);
        step();
        checkOutput("dup_c2_addr", 32'(mem_address), 32'h0002);
        checkOutput("dup_c2_wren", 32'(mem_wr_en), 32'd0);
        step();
        checkOutput("dup_c3_pulse", 32'(duplicate), 32'd1);
        checkOutput("dup_c3_new", 32'(new_sink), 32'd0);
        checkOutput("dup_c3_count", 32'(sink_count), 32'd2);

        // New ID after a two-entry scan: write 0x0007 to 0x0004 in cycle 3.
        sink_id    = 16'h0007;
        sink_valid = 1'b1;
        step();
        sink_valid = 1'b0;
        checkOutput("new3_c1_addr", 32'(mem_address), 32'h0000);
        step();
        checkOutput("new3_c2_addr", 32'(mem_address), 32'h0002);
        step();
        checkOutput("new3_c3_wren", 32'(mem_wr_en), 32'd1);
        checkOutput("new3_c3_addr", 32'(mem_address), 32'h0004);
        checkOutput("new3_c3_data", 32'(mem_wr_data), 32'h0007);
        step();
        checkOutput("new3_c4_new", 32'(new_sink), 32'd1);
        checkOutput("new3_c4_count", 32'(sink_count), 32'd3);

        clear = 1'b1;
        step();
        clear = 1'b0;
        checkOutput("clear_count", 32'(sink_count), 32'd0);

        // Fill to capacity: an ID offered to n entries pulses new_sink in cycle n+2.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(16'(i + 1), pc, pk, wr, wa);
            checkOutput($sformatf("fill%0d_cycle", i), 32'(pc), 32'(i + 2));
            checkOutput($sformatf("fill%0d_kind", i), 32'(pk), 32'd1);
        end
        checkOutput("fill_last_addr", 32'(wa), 32'h001E);
        checkOutput("fill_full", 32'(full), 32'd1);
        checkOutput("fill_count", 32'(sink_count), 32'd16);

        applyStimulus(16'h0011, pc, pk, wr, wa);
        checkOutput("drop_cycle", 32'(pc), 32'd17);
        checkOutput("drop_kind", 32'(pk), 32'd3);
        checkOutput("drop_writes", 32'(wr), 32'd0);
        checkOutput("drop_ready", 32'(sink_ready), 32'd1);

        applyStimulus(16'h0003, pc, pk, wr, wa);
        checkOutput("fulldup_cycle", 32'(pc), 32'd4);
        checkOutput("fulldup_kind", 32'(pk), 32'd2);

        // Clear in the middle of a scan over four entries.
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(16'(i + 5), pc, pk, wr, wa);
        checkOutput("four_count", 32'(sink_count), 32'd4);
        sink_id    = 16'h0009;
        sink_valid = 1'b1;
        step();
        sink_valid = 1'b0;
        step();
        checkOutput("midscan_busy", 32'(sink_ready), 32'd0);
        clear = 1'b1;
        step();
        clear = 1'b0;
        checkOutput("midscan_ready", 32'(sink_ready), 32'd1);
        checkOutput("midscan_count", 32'(sink_count), 32'd0);
        checkOutput("midscan_pulses", {29'd0, new_sink, duplicate, dropped}, 32'd0);
        step();
        checkOutput("midscan_later_pulses", {29'd0, new_sink, duplicate, dropped}, 32'd0);
        applyStimulus(16'h0005, pc, pk, wr, wa);
        checkOutput("stale_cycle", 32'(pc), 32'd2);
        checkOutput("stale_kind", 32'(pk), 32'd1);
        checkOutput("stale_addr", 32'(wa), 32'h0000);

        // Reset landing on a WRITE cycle must suppress the write.
        sink_id    = 16'h000A;
        sink_valid = 1'b1;
        step();
        sink_valid = 1'b0;
        step();
        checkOutput("rstw_wren_before", 32'(mem_wr_en), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("rstw_wren_gated", 32'(mem_wr_en), 32'd0);
        step();
        reset = 1'b0;
        #1;
        checkOutput("rstw_mem", 32'(mem[1]), 32'h0006);
        checkIdleResetValues("rstw");

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
